// File: rtl/neuro_pkg.sv
// Shared types and helpers for the neuromorphic spike-transport blocks.
package neuro_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFire,
    StGap,
    StRefrac
  } axon_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter; expired flags the final counted cycle (value == 1).
module cycle_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             expired
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign expired = (count_q == WIDTH'(1));

endmodule

// File: rtl/axon_tx.sv
// Single-axon spike transmitter: accepts a burst request, emits evenly spaced
// one-cycle spikes, then holds off new requests for a refractory period.
module axon_tx
  import neuro_pkg::*;
#(
  parameter int BURST_W    = 4,
  parameter int GAP        = 4,
  parameter int REFRACTORY = 16,
  parameter int COUNT_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  input  logic [BURST_W-1:0] req_burst,
  output logic               req_ready,
  input  logic               abort,
  output logic               spike,
  output logic               busy,
  output logic [COUNT_W-1:0] spike_count
);

  localparam int TIMER_W = $clog2(max_int(GAP, REFRACTORY) + 1);
  localparam logic [TIMER_W-1:0] GapLoad = TIMER_W'(GAP - 1);
  localparam logic [TIMER_W-1:0] RefLoad = TIMER_W'(REFRACTORY);

  if (GAP < 1) begin : g_gap_check
    $error("axon_tx: GAP must be >= 1");
  end
  if (REFRACTORY < 0) begin : g_refrac_check
    $error("axon_tx: REFRACTORY must be >= 0");
  end

  axon_state_t        state_q, state_d;
  logic [BURST_W-1:0] remaining_q;
  logic               timer_load;
  logic [TIMER_W-1:0] timer_val;
  logic               timer_expired;
  logic               last_spike;

  cycle_timer #(
    .WIDTH(TIMER_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (timer_load),
    .load_val(timer_val),
    .expired (timer_expired)
  );

  assign last_spike = (remaining_q == BURST_W'(1)) || abort;

  always_comb begin
    state_d    = state_q;
    timer_load = 1'b0;
    timer_val  = GapLoad;
    unique case (state_q)
      StIdle: begin
        // A zero-length request is consumed without leaving IDLE.
        if (req_valid && (req_burst != '0)) state_d = StFire;
      end
      StFire: begin
        if (last_spike) begin
          if (REFRACTORY == 0) begin
            state_d = StIdle;
          end else begin
            state_d    = StRefrac;
            timer_load = 1'b1;
            timer_val  = RefLoad;
          end
        end else if (GAP == 1) begin
          state_d = StFire;
        end else begin
          state_d    = StGap;
          timer_load = 1'b1;
          timer_val  = GapLoad;
        end
      end
      StGap: begin
        if (abort) begin
          if (REFRACTORY == 0) begin
            state_d = StIdle;
          end else begin
            state_d    = StRefrac;
            timer_load = 1'b1;
            timer_val  = RefLoad;
          end
        end else if (timer_expired) begin
          state_d = StFire;
        end
      end
      StRefrac: begin
        if (timer_expired) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they align with state_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      spike       <= 1'b0;
      busy        <= 1'b0;
      req_ready   <= 1'b1;
      spike_count <= '0;
    end else begin
      state_q   <= state_d;
      spike     <= (state_d == StFire);
      busy      <= (state_d != StIdle);
      req_ready <= (state_d == StIdle);

      if (state_q == StIdle && req_valid) begin
        remaining_q <= req_burst;
      end else if (state_d == StIdle || state_d == StRefrac) begin
        remaining_q <= '0;
      end else if (state_q == StFire) begin
        remaining_q <= remaining_q - BURST_W'(1);
      end

      if (state_q == StFire) spike_count <= spike_count + COUNT_W'(1);
    end
  end

endmodule

// File: doc/axon_tx.md
# axon_tx

Spike transmitter for one axon. It accepts burst requests over a valid/ready handshake and emits one-cycle `spike` pulses at a fixed inter-spike interval. After each burst it enforces a refractory period before accepting the next request. The `spike` output drives the `spike` net of the downstream `synapse_if` instances, which latch it into their sticky `spiked` flag.

## Interface

Parameters:
- `BURST_W`, default 4: width of the requested spike count.
- `GAP`, default 4: cycles between consecutive spike rising edges within a burst. Must be ≥ 1.
- `REFRACTORY`, default 16: idle cycles after the last spike of a burst. Must be ≥ 0.
- `COUNT_W`, default 8: width of the running spike counter.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  burst request present.
- `req_burst`  in  `BURST_W`  number of spikes to emit.
- `req_ready`  out  1  block can accept a request.
- `abort`  in  1  cancel the burst in progress.
- `spike`  out  1  one-cycle spike pulse, registered.
- `busy`  out  1  state is not IDLE.
- `spike_count`  out  `COUNT_W`  total spikes emitted, modulo 2^`COUNT_W`.

## Operation

The FSM has four states: IDLE, FIRE, GAP, REFRAC.

- **IDLE**
  - `req_ready`=1.
  - Handshake when `req_valid`&&`req_ready` at a clock edge.
  - `req_burst`≠0: load `remaining`=`req_burst` and go to FIRE.
  - `req_burst`=0: the request is consumed and the state stays IDLE. No spike and no refractory period.
- **FIRE**
  - `spike`=1 for this cycle and `spike_count`+=1.
  - If `remaining`==1 or `abort`: go to REFRAC, loading the timer with `REFRACTORY`. If `REFRACTORY`==0, go straight to IDLE.
  - Otherwise decrement `remaining`. If `GAP`==1, go to FIRE. Otherwise go to GAP, loading the timer with `GAP`-1.
- **GAP**
  - Timer decrements each cycle.
  - When the timer reaches 1, go to FIRE.
  - `abort` goes to REFRAC (same loading rule as above).
- **REFRAC**
  - Timer decrements each cycle; when it reaches 1, go to IDLE.
  - `abort` is ignored.

Output rules:
- `req_ready` is 1 only in IDLE.
- `busy` = (state≠IDLE).
- `spike` = (state==FIRE), decoded from registered state only, so it is glitch-free.
- `abort` in IDLE is ignored. `abort` together with `req_valid` in IDLE accepts the request.
- `spike_count` wraps silently.

## Timing

- **Reset:** asynchronous. While `reset` is asserted:
  - state=IDLE, `spike`=0, `busy`=0, `req_ready`=1, `spike_count`=0.
  - The timer and `remaining` are 0.
  - Reset asserted mid-burst kills the pulse immediately and drops the remaining spikes.
- **Latency:** the first spike is high in the cycle immediately after the handshake cycle.
- **Spacing:** spikes occur at cycles t+1, t+1+`GAP`, t+1+2·`GAP`, and so on.
- **Refractory:** after the last spike at cycle s, REFRAC occupies cycles s+1 … s+`REFRACTORY`, and `req_ready` returns at cycle s+`REFRACTORY`+1.
- **Abort in GAP:** sampled at cycle a, REFRAC begins at a+1.
- **Abort in FIRE:** the pulse in that cycle is still emitted and counted.
- **Back-to-back requests:** the minimum request-to-request spacing is `burst`·`GAP`−`GAP`+`REFRACTORY`+2 cycles.

## Structure

- Shared package `neuro_pkg` holds:
  - `axon_state_t` enum {IDLE, FIRE, GAP, REFRAC}.
  - Helper function `max_int` for sizing the timer.
- Timer width: `$clog2(max_int(GAP,REFRACTORY)+1)`.
- One natural sub-module, `cycle_timer`: a loadable down-counter with `load`, `load_val`, and `expired` (value==1). It is shared by the GAP and REFRAC states.
- Elaboration-time assertions: `GAP`≥1, `REFRACTORY`≥0.

## Test plan

All scenarios use defaults (`GAP`=4, `REFRACTORY`=16, `COUNT_W`=8) unless noted; the handshake is at cycle 0.

1. **Basic burst:** `req_burst`=3 → `spike` high in cycles 1, 5, 9. `req_ready` low in cycles 1–25 and high at 26. `spike_count`=3.
2. **Zero burst:** `req_burst`=0 → accepted at cycle 0, no spike, `busy` stays 0, `req_ready` stays 1, `spike_count` unchanged.
3. **Back-to-back pulses:** `GAP`=1, `req_burst`=4 → `spike` high continuously in cycles 1–4, `spike_count`+=4, `req_ready` high at cycle 21.
4. **Abort in GAP:** `req_burst`=5, `abort` pulsed at cycle 3 → single spike at cycle 1, REFRAC in cycles 4–19, `req_ready` at 20, `spike_count`=1.
5. **Counter wrap:** `GAP`=1, `REFRACTORY`=0, `BURST_W`=8, bursts totalling 256 spikes → `spike_count` reads 255 after spike 255 and 0 after spike 256.
6. **Async reset mid-burst:** `reset` asserted mid-GAP of a `req_burst`=3 burst → `spike`=0, `busy`=0, `spike_count`=0 without waiting for a clock edge. After release, a new `req_burst`=1 yields a spike exactly one cycle after its handshake.
